lsu_mem_ctrl: RTL and testbench
===============================

# lsu_mem_ctrl

Load/store unit controller between the core's execute stage and the data memory bus. Accepts one load or store per transaction from the core, drives a req/gnt/rvalid memory handshake, and returns aligned, sign- or zero-extended load data. That load data feeds the writeback selector's load-data input. The core is stalled while a transaction is outstanding.

## Interface
- TIMEOUT_CYCLES, default 255: bus watchdog limit in cycles; used only when LSU_TIMEOUT_EN is defined.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_lsu_valid  in  1  core request; held high with stable fields until o_lsu_done.
- i_lsu_we  in  1  1 = store, 0 = load.
- i_lsu_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW).
- i_lsu_addr  in  32  byte address.
- i_st_data  in  32  store data, LSB-aligned.
- o_ld_data  out  32  extended load result.
- o_lsu_done  out  1  one-cycle completion pulse.
- o_lsu_stall  out  1  core stall request.
- o_addr_exc  out  1  misaligned address or illegal funct3; valid with o_lsu_done.
- o_bus_err  out  1  watchdog abort; valid with o_lsu_done.
- o_mem_req  out  1  bus request.
- o_mem_we  out  1  bus write enable.
- o_mem_addr  out  32  word address, i_lsu_addr with bits [1:0] forced to 0.
- o_mem_wdata  out  32  lane-replicated store data.
- o_mem_be  out  4  byte enables.
- i_mem_gnt  in  1  request accepted.
- i_mem_rvalid  in  1  response: read data valid, or write acknowledge.
- i_mem_rdata  in  32  read data.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE
  - On i_lsu_valid, latch we, funct3, addr and st_data.
  - If the request is misaligned or has illegal funct3, go to DONE with exception flag set; no bus access is made.
  - Otherwise go to REQ.
- Exception conditions:
  - Illegal funct3: loads 011, 110, 111; stores other than 000, 001, 010.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0.
- REQ: o_mem_req=1, with address, we, be and wdata stable until i_mem_gnt is sampled high. Then go to WAIT.
- WAIT: on i_mem_rvalid, capture the result (loads only) and go to DONE. Stores also wait for rvalid as the write acknowledge.
- DONE: o_lsu_done=1 for exactly one cycle, then IDLE. o_addr_exc and o_bus_err are valid only in this cycle and 0 otherwise.
- Store lanes:
  - SB: be = 4'b0001 << addr[1:0]; wdata = {4{st[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{st[15:0]}}.
  - SW: be = 4'b1111; wdata = st.
- Loads: be = 4'b1111. Select the byte or halfword by addr[1:0], then sign-extend (LB/LH) or zero-extend (LBU/LHU).
- o_ld_data is registered and holds the last completed load. It is unchanged by stores, exceptions and bus errors.
- o_lsu_stall = i_lsu_valid & ~o_lsu_done (combinational).
- i_mem_rvalid is ignored outside WAIT. rvalid in the same cycle as gnt is a protocol violation and is ignored.

## Timing
- Reset: state IDLE; all outputs 0, including o_ld_data and o_mem_* outputs.
- Reset asserted mid-transaction drops o_mem_req immediately and aborts; no o_lsu_done is produced.
- Best-case latency: valid seen in cycle 0 → REQ with gnt in cycle 1 → WAIT with rvalid in cycle 2 → o_lsu_done in cycle 3.
- Each extra gnt or rvalid wait cycle adds one cycle of latency.
- Exception path: o_lsu_done in cycle 1 after valid.
- Back-to-back: the next request is accepted in the IDLE cycle following DONE.

## Configuration
- LSU_TIMEOUT_EN defined:
  - An 8-bit-or-wider counter resets on entry to REQ and increments in REQ and WAIT.
  - On reaching TIMEOUT_CYCLES, o_mem_req drops and the FSM goes to DONE with o_bus_err=1; o_ld_data is unchanged.
  - A late rvalid arriving afterward is ignored.
- LSU_TIMEOUT_EN undefined: no counter exists, o_bus_err is tied to 0, and the FSM waits indefinitely.

## Test plan
- LB at addr 0x103, rdata 0x80FF_1234 → o_ld_data 0xFFFF_FF80, done in cycle 3 with gnt and rvalid immediate.
- LHU at addr 0x102, rdata 0x8001_0000 → o_ld_data 0x0000_8001; o_mem_addr 0x100.
- SH at addr 0x206 with st_data 0x0000_ABCD → o_mem_be 4'b1100, o_mem_wdata 0xABCD_ABCD, o_mem_we=1; o_ld_data unchanged.
- LW at addr 0x101 → o_addr_exc=1 with done in cycle 1, o_mem_req never asserted; a following LW at 0x104 completes normally.
- gnt delayed 2 cycles and rvalid delayed 3 → done in cycle 8, with o_lsu_stall high throughout until done; reset pulsed in WAIT → all outputs 0 and state IDLE.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, gnt never asserted → o_bus_err=1 with o_lsu_done; a late rvalid afterward is ignored.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store unit controller driving a req/gnt/rvalid data bus.
// Optional bus watchdog enabled by defining LSU_TIMEOUT_EN.
`timescale 1ns/1ps
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_lsu_valid,
  input  logic        i_lsu_we,
  input  logic [2:0]  i_lsu_funct3,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  output logic [31:0] o_ld_data,
  output logic        o_lsu_done,
  output logic        o_lsu_stall,
  output logic        o_addr_exc,
  output logic        o_bus_err,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_be,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e      state_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [31:0] ld_data_q;
  logic        done_q;
  logic        addr_exc_q;
  logic        bus_err_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_be_q;

  logic        illegal_f3;
  logic        misaligned;
  logic        req_exc;
  logic [3:0]  st_be_d;
  logic [31:0] st_wdata_d;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data_d;
  logic        timeout;

  // Stores only have SB/SH/SW; loads additionally allow the unsigned LBU/LHU forms.
  assign illegal_f3 = i_lsu_we ? (i_lsu_funct3[2] | (i_lsu_funct3[1:0] == 2'b11))
                               : ((i_lsu_funct3 == 3'b011) | (i_lsu_funct3[2:1] == 2'b11));
  assign misaligned = ((i_lsu_funct3[1:0] == 2'b01) & i_lsu_addr[0]) |
                      ((i_lsu_funct3[1:0] == 2'b10) & (i_lsu_addr[1:0] != 2'b00));
  assign req_exc    = illegal_f3 | misaligned;

  always_comb begin
    st_be_d    = 4'b1111;
    st_wdata_d = 32'h0;
    if (i_lsu_we) begin
      case (i_lsu_funct3[1:0])
        2'b00: begin
          st_be_d    = 4'b0001 << i_lsu_addr[1:0];
          st_wdata_d = {4{i_st_data[7:0]}};
        end
        2'b01: begin
          st_be_d    = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
          st_wdata_d = {2{i_st_data[15:0]}};
        end
        default: begin
          st_be_d    = 4'b1111;
          st_wdata_d = i_st_data;
        end
      endcase
    end
  end

  assign ld_byte = i_mem_rdata[8*off_q +: 8];
  assign ld_half = off_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

  always_comb begin
    ld_data_d = i_mem_rdata;
    case (funct3_q)
      3'b000:  ld_data_d = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data_d = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data_d = {24'h0, ld_byte};
      3'b101:  ld_data_d = {16'h0, ld_half};
      default: ld_data_d = i_mem_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] cnt_q;

  // Cleared while idle so it starts from zero on every entry to REQ.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= '0;
    end
  end

  assign timeout = ((state_q == S_REQ) || (state_q == S_WAIT)) &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      ld_data_q   <= 32'h0;
      done_q      <= 1'b0;
      addr_exc_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_be_q    <= 4'b0000;
    end else begin
      done_q     <= 1'b0;
      addr_exc_q <= 1'b0;
      bus_err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_lsu_valid) begin
            we_q     <= i_lsu_we;
            funct3_q <= i_lsu_funct3;
            off_q    <= i_lsu_addr[1:0];
            if (req_exc) begin
              done_q     <= 1'b1;
              addr_exc_q <= 1'b1;
              state_q    <= S_DONE;
            end else begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= i_lsu_we;
              mem_addr_q  <= {i_lsu_addr[31:2], 2'b00};
              mem_be_q    <= st_be_d;
              mem_wdata_q <= st_wdata_d;
              state_q     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (i_mem_gnt) begin
            mem_req_q <= 1'b0;
            state_q   <= S_WAIT;
          end else if (timeout) begin
            mem_req_q <= 1'b0;
            done_q    <= 1'b1;
            bus_err_q <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        S_WAIT: begin
          // rvalid doubles as the write acknowledge, so stores wait here too.
          if (i_mem_rvalid) begin
            if (!we_q) begin
              ld_data_q <= ld_data_d;
            end
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (timeout) begin
            done_q    <= 1'b1;
            bus_err_q <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ld_data   = ld_data_q;
  assign o_lsu_done  = done_q;
  assign o_addr_exc  = addr_exc_q;
  assign o_bus_err   = bus_err_q;
  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_be    = mem_be_q;
  assign o_lsu_stall = i_lsu_valid & ~done_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - self-checking bench for lsu_mem_ctrl (timeout case under LSU_TIMEOUT_EN).
`timescale 1ns/1ps
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsu_valid = 1'b0;
  logic        lsu_we = 1'b0;
  logic [2:0]  lsu_funct3 = 3'b000;
  logic [31:0] lsu_addr = 32'h0;
  logic [31:0] st_data = 32'h0;
  logic [31:0] ld_data;
  logic        lsu_done;
  logic        lsu_stall;
  logic        addr_exc;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int          n_assert = 0;
  int          n_fail = 0;
  logic [31:0] last_ld = 32'h0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_lsu_valid  (lsu_valid),
    .i_lsu_we     (lsu_we),
    .i_lsu_funct3 (lsu_funct3),
    .i_lsu_addr   (lsu_addr),
    .i_st_data    (st_data),
    .o_ld_data    (ld_data),
    .o_lsu_done   (lsu_done),
    .o_lsu_stall  (lsu_stall),
    .o_addr_exc   (addr_exc),
    .o_bus_err    (bus_err),
    .o_mem_req    (mem_req),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .o_mem_be     (mem_be),
    .i_mem_gnt    (mem_gnt),
    .i_mem_rvalid (mem_rvalid),
    .i_mem_rdata  (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int access_bytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit model_exc(input bit we, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    if (we) legal = (f3 <= 3'd2);
    else    legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    if (!legal) return 1'b1;
    return (a % access_bytes(f3)) != 0;
  endfunction

  function automatic logic [31:0] model_ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int          n;
    logic [63:0] mask;
    logic [63:0] v;
    n    = access_bytes(f3);
    mask = (64'd1 << (8 * n)) - 64'd1;
    v    = {32'h0, rd >> (8 * int'(a[1:0]))} & mask;
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_be(input bit we, input logic [2:0] f3, input logic [31:0] a);
    int n;
    if (!we) return 4'b1111;
    n = access_bytes(f3);
    return 4'(((1 << n) - 1) << int'(a[1:0]));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] st);
    logic [31:0] w;
    int          n;
    n = access_bytes(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = st[8*(i % n) +: 8];
    return w;
  endfunction

  // Entered just after a rising edge; that cycle is cycle 0 of the transaction.
  task automatic run_txn(input bit we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] st, input logic [31:0] rd,
                         input int gd, input int rdl, input bit rv_with_gnt);
    bit  exc;
    int  exp_dc;
    int  req_cyc;
    int  wait_cyc;
    int  req_hi;
    bit  in_wait;
    bit  seen_done;
    bit  bus_checked;
    exc         = model_exc(we, f3, a);
    exp_dc      = exc ? 1 : 3 + gd + rdl;
    req_cyc     = 0;
    wait_cyc    = 0;
    req_hi      = 0;
    in_wait     = 1'b0;
    seen_done   = 1'b0;
    bus_checked = 1'b0;
    lsu_valid   = 1'b1;
    lsu_we      = we;
    lsu_funct3  = f3;
    lsu_addr    = a;
    st_data     = st;
    mem_rdata   = rd;
    mem_gnt     = 1'b0;
    mem_rvalid  = 1'b0;
    for (int cyc = 0; cyc <= exp_dc + 4 && !seen_done; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk);
        #1;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        if (in_wait) begin
          mem_rvalid = (wait_cyc == rdl);
          wait_cyc++;
        end else if (mem_req) begin
          if (req_cyc == gd) begin
            mem_gnt    = 1'b1;
            mem_rvalid = rv_with_gnt;
            in_wait    = 1'b1;
          end
          req_cyc++;
        end
      end
      @(negedge clk);
      if (mem_req) begin
        req_hi++;
        if (!bus_checked) begin
          bus_checked = 1'b1;
          chk("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
          chk("mem_we", {31'h0, mem_we}, {31'h0, we});
          chk("mem_be", {28'h0, mem_be}, {28'h0, model_be(we, f3, a)});
          if (we) chk("mem_wdata", mem_wdata, model_wdata(f3, st));
        end
      end
      chk("done", {31'h0, lsu_done}, {31'h0, cyc == exp_dc});
      chk("stall", {31'h0, lsu_stall}, {31'h0, cyc != exp_dc});
      if (lsu_done) begin
        seen_done = 1'b1;
        if (!exc && !we) last_ld = model_ld(f3, a, rd);
        chk("addr_exc", {31'h0, addr_exc}, {31'h0, exc});
        chk("bus_err", {31'h0, bus_err}, 32'h0);
        chk("ld_data", ld_data, last_ld);
        chk("req_cycles", req_hi, exc ? 0 : gd + 1);
      end
    end
    if (!seen_done) chk("done_seen", 32'h0, 32'h1);
    @(posedge clk);
    #1;
    lsu_valid  = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ld_data"}, ld_data, 32'h0);
    chk({tag, "_ctrl"}, {26'h0, lsu_done, lsu_stall, addr_exc, bus_err, mem_req, mem_we}, 32'h0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_mem_be"}, {28'h0, mem_be}, 32'h0);
  endtask

  initial begin
    bit          rwe;
    logic [2:0]  rf3;
    logic [31:0] ra;
    logic [2:0]  ld_ok[5];
    ld_ok = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    // Reset state
    #2;
    chk_all_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed cases
    run_txn(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0, 0, 1'b0);
    chk("lb_value", ld_data, 32'hFFFF_FF80);
    run_txn(1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'h8001_0000, 0, 0, 1'b0);
    chk("lhu_value", ld_data, 32'h0000_8001);
    run_txn(1'b1, 3'b001, 32'h0000_0206, 32'h0000_ABCD, 32'hDEAD_BEEF, 0, 0, 1'b0);
    chk("sh_keeps_ld", ld_data, 32'h0000_8001);
    run_txn(1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h1111_2222, 0, 0, 1'b0);
    run_txn(1'b0, 3'b010, 32'h0000_0104, 32'h0, 32'hCAFE_F00D, 0, 0, 1'b0);
    chk("lw_value", ld_data, 32'hCAFE_F00D);
    run_txn(1'b0, 3'b010, 32'h0000_0108, 32'h0, 32'h1357_9BDF, 2, 3, 1'b0);
    run_txn(1'b1, 3'b011, 32'h0000_0200, 32'h1234_5678, 32'h0, 0, 0, 1'b0);
    run_txn(1'b0, 3'b111, 32'h0000_0200, 32'h0, 32'h0, 0, 0, 1'b0);

    // Randomized traffic, back-to-back
    for (int k = 0; k < 40; k++) begin
      rwe = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) rf3 = rwe ? 3'($urandom_range(0, 2)) : ld_ok[$urandom_range(0, 4)];
      else                          rf3 = 3'($urandom_range(0, 7));
      ra = 32'h1000 + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) ra = ra & ~32'(access_bytes(rf3) - 1);
      run_txn(rwe, rf3, ra, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
              1'($urandom_range(0, 1)));
    end

    // Reset pulsed while waiting for rvalid
    lsu_valid  = 1'b1;
    lsu_we     = 1'b0;
    lsu_funct3 = 3'b010;
    lsu_addr   = 32'h0000_0300;
    @(posedge clk);
    #1;
    mem_gnt = 1'b1;
    @(posedge clk);
    #1;
    mem_gnt = 1'b0;
    @(negedge clk);
    #2;
    rst_n     = 1'b0;
    lsu_valid = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    last_ld = 32'h0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_done_after_reset", {31'h0, lsu_done}, 32'h0);
    end
    @(posedge clk);
    #1;
    run_txn(1'b0, 3'b100, 32'h0000_0311, 32'h0, 32'h0000_9A00, 1, 0, 1'b0);
    chk("lbu_after_reset", ld_data, 32'h0000_009A);

`ifdef LSU_TIMEOUT_EN
    begin
      bit seen;
      seen       = 1'b0;
      lsu_valid  = 1'b1;
      lsu_we     = 1'b0;
      lsu_funct3 = 3'b010;
      lsu_addr   = 32'h0000_0400;
      mem_rdata  = 32'h5555_AAAA;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (lsu_done) begin
          seen = 1'b1;
          chk("to_bus_err", {31'h0, bus_err}, 32'h1);
          chk("to_addr_exc", {31'h0, addr_exc}, 32'h0);
          chk("to_ld_kept", ld_data, 32'h0000_009A);
          chk("to_req_dropped", {31'h0, mem_req}, 32'h0);
        end
      end
      if (!seen) chk("to_done_seen", 32'h0, 32'h1);
      @(posedge clk);
      #1;
      lsu_valid  = 1'b0;
      mem_rvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("late_rvalid_no_done", {31'h0, lsu_done}, 32'h0);
        chk("late_rvalid_ld", ld_data, 32'h0000_009A);
      end
      mem_rvalid = 1'b0;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
